// File: rtl/vga_pattern_gen.sv
// Purpose : parametrised VGA test-pattern generator (8 patterns, incl. frame-scrolled bars),
//           placed directly after the timing generator.
// Latency : fixed 2 cycles from Xpix/Ypix/disp_enable/syncs to r/g/b/syncs/de_out.
// Backpressure: none; a pixel-rate stream that accepts and emits one pixel every clock.
//
// Ports:
//   clk, rst              pixel clock, asynchronous active-high reset
//   Xpix, Ypix            pixel coordinates from the timing generator (unsigned)
//   disp_enable           active-area flag; hsync_in / vsync_in active at SYNC_ACTIVE
//   mode                  pattern select, latched only at frame start (vsync going active)
//   r, g, b               COLOR_W-bit colour, forced to 0 outside the active area
//   hsync_out, vsync_out, de_out   inputs delayed to line up with r/g/b
//   frame_cnt             frames since reset, wraps 65535 -> 0
// Optional: define TPG_BORDER_EN to force a white one-pixel border around the active area.
module vga_pattern_gen #(
    parameter int   COLOR_W     = 4,
    parameter int   H_DISP      = 1280,
    parameter int   V_DISP      = 1024,
    parameter int   CHECK_LOG2  = 5,
    parameter int   GRAD_SHIFT  = 4,
    parameter int   SCROLL_STEP = 8,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        Xpix,
    input  logic [31:0]        Ypix,
    input  logic               disp_enable,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic [2:0]         mode,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               de_out,
    output logic [15:0]        frame_cnt
);

    localparam int          BAR_W    = H_DISP / 8;
    localparam logic [32:0] H_DISP_W = 33'(H_DISP);

    // frame-level state
    logic               vs_hist_q, vs_hist_d;
    logic [2:0]         mode_q, mode_d;
    logic [15:0]        frame_q, frame_d;
    logic [31:0]        offset_q, offset_d;

    // stage 1
    logic               de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    logic [2:0]         idx1_q, idx1_d;
    logic               chk1_q, chk1_d;
    logic               border1_q, border1_d;
    logic [COLOR_W-1:0] lvlx1_q, lvlx1_d, lvly1_q, lvly1_d;

    // stage 2
    logic [COLOR_W-1:0] r2_q, r2_d, g2_q, g2_d, b2_q, b2_d;
    logic               de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d;

    logic               frame_start;
    logic [31:0]        off_sum;
    logic [32:0]        xs_sum, xs, x_sel, bar;

`ifndef TPG_BORDER_EN
    // Without the border only a few Ypix bits matter and V_DISP has no use.
    logic border_unused;
    assign border_unused = ^Ypix ^ (V_DISP > 0);
`endif

    // Frame state: a frame starts when vsync goes inactive -> active.
    always_comb begin
        frame_start = (vsync_in == SYNC_ACTIVE) && (vs_hist_q != SYNC_ACTIVE);
        vs_hist_d   = vsync_in;
        mode_d      = mode_q;
        frame_d     = frame_q;
        offset_d    = offset_q;
        off_sum     = offset_q + 32'(SCROLL_STEP);
        if (frame_start) begin
            mode_d   = mode;
            frame_d  = frame_q + 16'd1;
            offset_d = (off_sum >= 32'(H_DISP)) ? off_sum - 32'(H_DISP) : off_sum;
        end
    end

    // Stage 1: bar index (from plain or scrolled X), checker bit, gradient levels.
    always_comb begin
        de1_d   = disp_enable;
        hs1_d   = hsync_in;
        vs1_d   = vsync_in;
        // 33-bit sum so an out-of-range Xpix cannot wrap back into the screen.
        xs_sum  = {1'b0, Xpix} + {1'b0, offset_q};
        xs      = (xs_sum >= H_DISP_W) ? xs_sum - H_DISP_W : xs_sum;
        x_sel   = (mode_q == 3'd6) ? xs : {1'b0, Xpix};
        bar     = x_sel / 33'(BAR_W);
        idx1_d  = (bar > 33'd7) ? 3'd7 : bar[2:0];
        chk1_d  = Xpix[CHECK_LOG2] ^ Ypix[CHECK_LOG2];
        lvlx1_d = Xpix[GRAD_SHIFT +: COLOR_W];
        lvly1_d = Ypix[GRAD_SHIFT +: COLOR_W];
`ifdef TPG_BORDER_EN
        border1_d = (Xpix == 32'd0) || (Xpix == 32'(H_DISP - 1)) ||
                    (Ypix == 32'd0) || (Ypix == 32'(V_DISP - 1));
`else
        border1_d = 1'b0;
`endif
    end

    // Stage 2: colour per pattern, then border override, then blanking.
    always_comb begin
        r2_d  = '0;
        g2_d  = '0;
        b2_d  = '0;
        de2_d = de1_q;
        hs2_d = hs1_q;
        vs2_d = vs1_q;
        case (mode_q)
            3'd1: begin
                r2_d = '1; g2_d = '1; b2_d = '1;
            end
            3'd2, 3'd6: begin
                r2_d = {COLOR_W{~idx1_q[1]}};
                g2_d = {COLOR_W{~idx1_q[2]}};
                b2_d = {COLOR_W{~idx1_q[0]}};
            end
            3'd3: begin
                r2_d = {COLOR_W{chk1_q}};
                g2_d = {COLOR_W{chk1_q}};
                b2_d = {COLOR_W{chk1_q}};
            end
            3'd4: begin
                r2_d = lvlx1_q; g2_d = lvlx1_q; b2_d = lvlx1_q;
            end
            3'd5: begin
                r2_d = lvly1_q; g2_d = lvly1_q; b2_d = lvly1_q;
            end
            3'd7: begin
                r2_d = lvlx1_q;
            end
            default: begin
                r2_d = '0; g2_d = '0; b2_d = '0;
            end
        endcase
        if (border1_q) begin
            r2_d = '1; g2_d = '1; b2_d = '1;
        end
        if (!de1_q) begin
            r2_d = '0; g2_d = '0; b2_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_hist_q <= ~SYNC_ACTIVE;
            mode_q    <= 3'd0;
            frame_q   <= 16'd0;
            offset_q  <= 32'd0;
            de1_q     <= 1'b0;
            hs1_q     <= ~SYNC_ACTIVE;
            vs1_q     <= ~SYNC_ACTIVE;
            idx1_q    <= 3'd0;
            chk1_q    <= 1'b0;
            border1_q <= 1'b0;
            lvlx1_q   <= '0;
            lvly1_q   <= '0;
            r2_q      <= '0;
            g2_q      <= '0;
            b2_q      <= '0;
            de2_q     <= 1'b0;
            hs2_q     <= ~SYNC_ACTIVE;
            vs2_q     <= ~SYNC_ACTIVE;
        end else begin
            vs_hist_q <= vs_hist_d;
            mode_q    <= mode_d;
            frame_q   <= frame_d;
            offset_q  <= offset_d;
            de1_q     <= de1_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            idx1_q    <= idx1_d;
            chk1_q    <= chk1_d;
            border1_q <= border1_d;
            lvlx1_q   <= lvlx1_d;
            lvly1_q   <= lvly1_d;
            r2_q      <= r2_d;
            g2_q      <= g2_d;
            b2_q      <= b2_d;
            de2_q     <= de2_d;
            hs2_q     <= hs2_d;
            vs2_q     <= vs2_d;
        end
    end

    assign r         = r2_q;
    assign g         = g2_q;
    assign b         = b2_q;
    assign de_out    = de2_q;
    assign hsync_out = hs2_q;
    assign vsync_out = vs2_q;
    assign frame_cnt = frame_q;

endmodule
